// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and source index for the register-file writeback arbiter.
package rf_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/response bundle between the ALU/memory stages and the arbiter.
interface regfile_wb_arbiter_if;
  import rf_pkg::*;

  logic              AluValid;
  logic [ADDR_W-1:0] AluRW;
  logic [DATA_W-1:0] AluData;
  logic              AluReady;
  logic              MemValid;
  logic [ADDR_W-1:0] MemRW;
  logic [DATA_W-1:0] MemData;
  logic              MemReady;
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] BusW;
  logic              RegWr;
  logic              Busy;

  modport master (
    output AluValid, AluRW, AluData, MemValid, MemRW, MemData,
    input  AluReady, MemReady, RW, BusW, RegWr, Busy
  );

  modport slave (
    input  AluValid, AluRW, AluData, MemValid, MemRW, MemData,
    output AluReady, MemReady, RW, BusW, RegWr, Busy
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One-entry writeback holding buffer; requests to the hard-zero register are accepted but dropped.
module wb_slot
  import rf_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] rw_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              grant_i,
  output logic              ready_o,
  output logic              load_o,
  output logic              full_o,
  output logic [ADDR_W-1:0] rw_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept;

  // A granted entry leaves at this edge, so the slot can take a new one in the same cycle.
  assign ready_o = ~rst_i & (~full_q | grant_i);
  assign accept  = valid_i & ready_o;
  assign load_o  = accept & (rw_i != ZERO_REG);

  always_comb begin
    full_d = full_q;
    rw_d   = rw_q;
    data_d = data_q;
    if (grant_i) begin
      full_d = 1'b0;
    end
    if (load_o) begin
      full_d = 1'b1;
      rw_d   = rw_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      rw_q   <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      rw_q   <= rw_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign rw_o   = rw_q;
  assign data_o = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Oldest-first arbiter sharing the register-file write port between ALU and load writebacks.
// Define RF_WB_FWD_EN to add RA/RB bypass outputs from the registered write command.
module regfile_wb_arbiter
  import rf_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  regfile_wb_arbiter_if.slave bus
`ifdef RF_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic              FwdA,
  output logic              FwdB,
  output logic [DATA_W-1:0] FwdDataA,
  output logic [DATA_W-1:0] FwdDataB
`endif
);

  logic              alu_full, mem_full;
  logic              alu_load, mem_load;
  logic              alu_grant, mem_grant;
  logic [ADDR_W-1:0] alu_rw, mem_rw;
  logic [DATA_W-1:0] alu_data, mem_data;

  logic              gnt_valid;
  src_e              gnt_src;
  logic              mem_older_q, mem_older_d;
  logic              reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] busw_q, busw_d;

  wb_slot u_alu_slot (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .valid_i (bus.AluValid),
    .rw_i    (bus.AluRW),
    .data_i  (bus.AluData),
    .grant_i (alu_grant),
    .ready_o (bus.AluReady),
    .load_o  (alu_load),
    .full_o  (alu_full),
    .rw_o    (alu_rw),
    .data_o  (alu_data)
  );

  wb_slot u_mem_slot (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .valid_i (bus.MemValid),
    .rw_i    (bus.MemRW),
    .data_i  (bus.MemData),
    .grant_i (mem_grant),
    .ready_o (bus.MemReady),
    .load_o  (mem_load),
    .full_o  (mem_full),
    .rw_o    (mem_rw),
    .data_o  (mem_data)
  );

  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = SRC_ALU;
    unique case ({mem_full, alu_full})
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_ALU;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_MEM;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_src   = mem_older_q ? SRC_MEM : SRC_ALU;
      end
      default: ;
    endcase
  end

  assign alu_grant = gnt_valid & (gnt_src == SRC_ALU);
  assign mem_grant = gnt_valid & (gnt_src == SRC_MEM);

  // A fresh ALU entry is always younger than Mem, including a same-edge load of both.
  always_comb begin
    mem_older_d = mem_older_q;
    if (alu_load) begin
      mem_older_d = 1'b1;
    end else if (mem_load) begin
      mem_older_d = 1'b0;
    end
  end

  always_comb begin
    reg_wr_d = gnt_valid;
    rw_d     = rw_q;
    busw_d   = busw_q;
    if (mem_grant) begin
      rw_d   = mem_rw;
      busw_d = mem_data;
    end else if (alu_grant) begin
      rw_d   = alu_rw;
      busw_d = alu_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_older_q <= 1'b0;
      reg_wr_q    <= 1'b0;
      rw_q        <= '0;
      busw_q      <= '0;
    end else begin
      mem_older_q <= mem_older_d;
      reg_wr_q    <= reg_wr_d;
      rw_q        <= rw_d;
      busw_q      <= busw_d;
    end
  end

  assign bus.RegWr = reg_wr_q;
  assign bus.RW    = rw_q;
  assign bus.BusW  = busw_q;
  assign bus.Busy  = alu_full | mem_full;

`ifdef RF_WB_FWD_EN
  // Covers reads issued before the falling-edge write reaches the register file.
  assign FwdA     = reg_wr_q & (rw_q == RA) & (RA != ZERO_REG);
  assign FwdB     = reg_wr_q & (rw_q == RB) & (RB != ZERO_REG);
  assign FwdDataA = FwdA ? busw_q : '0;
  assign FwdDataB = FwdB ? busw_q : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against an age-stamped buffer model.
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  logic Clk = 1'b0;
  logic Reset;

  regfile_wb_arbiter_if bus ();

`ifdef RF_WB_FWD_EN
  logic [ADDR_W-1:0] RA, RB;
  logic              FwdA, FwdB;
  logic [DATA_W-1:0] FwdDataA, FwdDataB;
`endif

  regfile_wb_arbiter dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus)
`ifdef RF_WB_FWD_EN
    ,
    .RA       (RA),
    .RB       (RB),
    .FwdA     (FwdA),
    .FwdB     (FwdB),
    .FwdDataA (FwdDataA),
    .FwdDataB (FwdDataB)
`endif
  );

  always #5 Clk = ~Clk;

  // Model: index 0 = Mem, 1 = Alu. Lower stamp is older; same-edge loads favour Mem.
  typedef struct {
    bit                full;
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] data;
    int                stamp;
  } mbuf_t;

  mbuf_t             m_buf [2];
  bit                m_regwr;
  logic [ADDR_W-1:0] m_rw;
  logic [DATA_W-1:0] m_busw;
  int                cyc;
  int                errors;
  int                checks;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    int g = -1;
    for (int s = 0; s < 2; s++) begin
      if (m_buf[s].full && (g < 0 || m_buf[s].stamp < m_buf[g].stamp)) g = s;
    end
    return g;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      m_buf[s].full  = 1'b0;
      m_buf[s].rw    = '0;
      m_buf[s].data  = '0;
      m_buf[s].stamp = 0;
    end
    m_regwr = 1'b0;
    m_rw    = '0;
    m_busw  = '0;
  endtask

  task automatic step(input bit rst, input bit av, input logic [ADDR_W-1:0] arw,
                      input logic [DATA_W-1:0] ad, input bit mv, input logic [ADDR_W-1:0] mrw,
                      input logic [DATA_W-1:0] md);
    int                g;
    bit                rdy [2];
    bit                v   [2];
    logic [ADDR_W-1:0] rws [2];
    logic [DATA_W-1:0] ds  [2];
    v[0] = mv;  rws[0] = mrw;  ds[0] = md;
    v[1] = av;  rws[1] = arw;  ds[1] = ad;

    @(negedge Clk);
    Reset        = rst;
    bus.AluValid = av;
    bus.AluRW    = arw;
    bus.AluData  = ad;
    bus.MemValid = mv;
    bus.MemRW    = mrw;
    bus.MemData  = md;
`ifdef RF_WB_FWD_EN
    RA = ($urandom_range(0, 1) == 1) ? m_rw : ADDR_W'($urandom_range(0, 31));
    RB = ($urandom_range(0, 1) == 1) ? m_rw : ADDR_W'($urandom_range(0, 31));
`endif
    #1;
    g = model_grant();
    for (int s = 0; s < 2; s++) rdy[s] = !rst && (!m_buf[s].full || g == s);
    check_eq("alu_ready", bus.AluReady, rdy[1]);
    check_eq("mem_ready", bus.MemReady, rdy[0]);
    check_eq("busy", bus.Busy, m_buf[0].full || m_buf[1].full);
    check_eq("regwr", bus.RegWr, m_regwr);
    check_eq("rw", bus.RW, m_rw);
    check_eq("busw", bus.BusW, m_busw);
`ifdef RF_WB_FWD_EN
    begin
      bit fa, fb;
      fa = m_regwr && (m_rw == RA) && (RA != ZERO_REG);
      fb = m_regwr && (m_rw == RB) && (RB != ZERO_REG);
      check_eq("fwd_a", FwdA, fa);
      check_eq("fwd_b", FwdB, fb);
      check_eq("fwd_data_a", FwdDataA, fa ? m_busw : 64'd0);
      check_eq("fwd_data_b", FwdDataB, fb ? m_busw : 64'd0);
    end
`endif

    @(posedge Clk);
    if (rst) begin
      model_clear();
    end else begin
      m_regwr = (g >= 0);
      if (g >= 0) begin
        m_rw          = m_buf[g].rw;
        m_busw        = m_buf[g].data;
        m_buf[g].full = 1'b0;
      end
      for (int s = 0; s < 2; s++) begin
        if (v[s] && rdy[s] && rws[s] != ZERO_REG) begin
          m_buf[s].full  = 1'b1;
          m_buf[s].rw    = rws[s];
          m_buf[s].data  = ds[s];
          m_buf[s].stamp = cyc * 2 + s;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 1;
    model_clear();
    Reset        = 1'b1;
    bus.AluValid = 1'b0;
    bus.AluRW    = '0;
    bus.AluData  = '0;
    bus.MemValid = 1'b0;
    bus.MemRW    = '0;
    bus.MemData  = '0;
`ifdef RF_WB_FWD_EN
    RA = '0;
    RB = '0;
`endif
    repeat (2) @(posedge Clk);

    // Requests during reset are ignored
    step(1'b1, 1'b1, 5'd3, 64'h33, 1'b0, '0, '0);
    step(1'b1, 1'b1, 5'd3, 64'h33, 1'b0, '0, '0);
    idle(2);

    // ALU streaming
    step(1'b0, 1'b1, 5'd1, 64'hA, 1'b0, '0, '0);
    step(1'b0, 1'b1, 5'd2, 64'hB, 1'b0, '0, '0);
    step(1'b0, 1'b1, 5'd3, 64'hC, 1'b0, '0, '0);
    idle(2);

    // Same edge, same destination: Mem written first
    step(1'b0, 1'b1, 5'd5, 64'h11, 1'b1, 5'd5, 64'h22);
    idle(3);

    // Hard-zero register drop
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd31, 64'hFF);
    idle(2);

    // Age ordering
    step(1'b0, 1'b1, 5'd9, 64'h99, 1'b1, 5'd12, 64'h12);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 64'h77);
    step(1'b0, 1'b1, 5'd8, 64'h88, 1'b0, '0, '0);
    idle(3);

    // Reset with both buffers full
    step(1'b0, 1'b1, 5'd4, 64'h44, 1'b1, 5'd6, 64'h66);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0,
           1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), {$urandom, $urandom});
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
